fp_add_scheduler: RTL and testbench
===================================

FP_ADD_SCHEDULER -- requirements
Module: fp_add_scheduler

Interface
REQ-001 SHALL have port clk, input, 1: single clock; all flops update on rising edge.
REQ-002 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-003 SHALL have ports req0_valid / req1_valid, input, 1: requester N presents an operand pair.
REQ-004 SHALL have ports req0_a, req0_b, req1_a, req1_b, input, 8 each: {sign, exp[2:0], frac[3:0]}, value (-1)^s x 1.frac x 2^(exp-3).
REQ-005 SHALL have ports req0_ready / req1_ready, output, 1: transfer occurs on a clock edge where valid and ready are both 1.
REQ-006 SHALL have port res_valid, output, 1: result available.
REQ-007 SHALL have port res_ready, input, 1: consumer accepts result.
REQ-008 SHALL have port res_data, output, 8: normalized sum in the same 8-bit format.
REQ-009 SHALL have port res_id, output, 1: index of the requester that owns res_data.
REQ-010 SHALL have ports res_zero, res_ovf, res_unf, output, 1 each: exact-zero, saturated-overflow and flush-to-zero flags.

Function
REQ-011 SHALL implement FSM states IDLE, ADD, NORM, DONE.
REQ-012 SHALL drive reqN_ready = (state==IDLE) & grantN; at most one ready high per cycle.
REQ-013 SHALL grant round-robin: single requester valid -> grant it; both valid -> grant the one not granted last.
REQ-014 SHALL, on acceptance, latch a, b and id, then go IDLE->ADD.
REQ-015 ADD SHALL register, from sub-module output, raw sign, larger exponent and 6-bit magnitude (hidden 1 restored, smaller operand right-shifted by exponent difference, truncated, signed add), then go ->NORM.
REQ-016 NORM SHALL do one step per cycle: mag==0 -> final result 0x00 with res_zero=1; mag[5]==1 -> shift right 1 (truncate), exp+1; mag[5:4]==00 -> shift left 1, exp-1; mag[5:4]==01 -> final result {sign, exp, mag[3:0]}.
REQ-017 Right shift with exp==7 SHALL finish immediately as saturated {sign,111,1111} with res_ovf=1.
REQ-018 Left shift with exp==0 SHALL finish immediately as 0x00 with res_unf=1 and res_zero=1.
REQ-019 The final-result edge SHALL register res_data, res_id and flags, and go NORM->DONE.
REQ-020 Latency: acceptance at edge E0 -> res_valid high after edge E2+n, where n = number of shift steps (0..4).
REQ-021 DONE SHALL hold res_valid=1 with res_data, res_id and flags stable until res_ready=1; then go ->IDLE, clearing res_valid.
REQ-022 The next acceptance SHALL occur no earlier than the edge after the DONE->IDLE edge; there is no bypass.
REQ-023 Requesters SHALL be ignored outside IDLE, and their inputs need not be held after acceptance.

Reset
REQ-024 Reset SHALL force IDLE; res_valid, res_data, res_id, res_zero, res_ovf and res_unf SHALL be 0, and both readies SHALL be 0 until the first post-reset edge.
REQ-025 The last-grant register SHALL reset to 1 so req0 wins the first contention.
REQ-026 Reset asserted mid-operation SHALL discard the in-flight operation without emitting a result.

Structure
REQ-027 Shared package fp8_pkg SHALL hold: field widths (EXP_W=3, FRAC_W=4, MAG_W=6), BIAS=3, MAX_MAG=8'h7F, and the FSM state enum.
REQ-028 SHALL instantiate one combinational sub-module fp_add8_core (align + signed add -> sign, exp, 6-bit magnitude).
REQ-029 Sequencing, arbitration and normalization SHALL reside in fp_add_scheduler.

Verification
REQ-030 req0 only: a=0x52, b=0x42 (4.5+2.25) -> res_valid 2 cycles after accept; res_data=0x5B, res_id=0, all flags 0.
REQ-031 req1 only: a=0xD2, b=0x42 (-4.5+2.25) -> one left shift; res_data=0xC2, res_id=1, valid 3 cycles after accept.
REQ-032 Both valid back-to-back, res_ready=1: grant order req0, req1, req0; readies never high simultaneously.
REQ-033 a=0x7F, b=0x7F -> res_data=0x7F, res_ovf=1; a=0x52, b=0xD2 -> res_data=0x00, res_zero=1.
REQ-034 a=0x05, b=0x80 (1.3125-1.0) -> shift to exp 0 boundary -> res_data=0x00, res_unf=1, res_zero=1.
REQ-035 Hold res_ready=0 for 5 cycles in DONE, then assert reset during a later NORM -> outputs stable while stalled; after reset all outputs 0, state IDLE, no spurious res_valid.

Source files
------------

// File: rtl/fp8_pkg.sv
// Shared definitions for the 8-bit {sign, exp[2:0], frac[3:0]} adder and its scheduler.
// Value encoding: (-1)^s x 1.frac x 2^(exp-BIAS).
package fp8_pkg;

    localparam int EXP_W  = 3;
    localparam int FRAC_W = 4;
    localparam int MAG_W  = 6;
    localparam int BIAS   = 3;

    localparam logic [7:0]       MAX_MAG = 8'h7F;
    localparam logic [EXP_W-1:0] EXP_MAX = '1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        NORM = 2'd2,
        DONE = 2'd3
    } state_t;

    function automatic logic [7:0] pack_fp(input logic s, input logic [EXP_W-1:0] e,
                                           input logic [FRAC_W-1:0] f);
        return {s, e, f};
    endfunction

endpackage

// File: rtl/fp_add8_core.sv
// Combinational align-and-add: restores hidden bits, right-aligns the operand with the
// smaller exponent (truncating), and forms a signed sum as sign + 6-bit magnitude.
module fp_add8_core
    import fp8_pkg::*;
(
    input  logic [7:0]       a,
    input  logic [7:0]       b,
    output logic             sum_sign,
    output logic [EXP_W-1:0] sum_exp,
    output logic [MAG_W-1:0] sum_mag
);

    logic             sa;
    logic             sb;
    logic [EXP_W-1:0] ea;
    logic [EXP_W-1:0] eb;
    logic [FRAC_W:0]  ma;
    logic [FRAC_W:0]  mb;
    logic             a_big;
    logic             s_big;
    logic             s_sml;
    logic [EXP_W-1:0] e_big;
    logic [EXP_W-1:0] e_diff;
    logic [FRAC_W:0]  m_sml;
    logic [MAG_W-1:0] m_big6;
    logic [MAG_W-1:0] m_sh6;

    always_comb begin
        sa = a[7];
        sb = b[7];
        ea = a[6:4];
        eb = b[6:4];
        ma = {1'b1, a[3:0]};
        mb = {1'b1, b[3:0]};

        // Operand order is decided on exponent alone; mantissa ties are resolved below.
        a_big  = (ea >= eb);
        s_big  = a_big ? sa : sb;
        s_sml  = a_big ? sb : sa;
        e_big  = a_big ? ea : eb;
        e_diff = a_big ? (ea - eb) : (eb - ea);
        m_big6 = {1'b0, (a_big ? ma : mb)};
        m_sml  = a_big ? mb : ma;
        m_sh6  = {1'b0, (m_sml >> e_diff)};

        sum_exp = e_big;
        if (s_big == s_sml) begin
            sum_sign = s_big;
            sum_mag  = m_big6 + m_sh6;
        end else if (m_big6 >= m_sh6) begin
            sum_sign = s_big;
            sum_mag  = m_big6 - m_sh6;
        end else begin
            sum_sign = s_sml;
            sum_mag  = m_sh6 - m_big6;
        end
    end

endmodule

// File: rtl/fp_add_scheduler.sv
// Two-requester round-robin front end feeding one fp8 adder, with a one-step-per-cycle
// normalizer and a held result register. Requests are taken only in IDLE.
module fp_add_scheduler
    import fp8_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       req0_valid,
    input  logic [7:0] req0_a,
    input  logic [7:0] req0_b,
    output logic       req0_ready,
    input  logic       req1_valid,
    input  logic [7:0] req1_a,
    input  logic [7:0] req1_b,
    output logic       req1_ready,
    output logic       res_valid,
    input  logic       res_ready,
    output logic [7:0] res_data,
    output logic       res_id,
    output logic       res_zero,
    output logic       res_ovf,
    output logic       res_unf,
    output state_t     dbg_state
);

    // Handshake: a transfer happens on a rising edge where valid and ready are both 1.
    // Requester ready is combinational from state and grant; res_valid stays high with
    // stable data/id/flags until the edge on which res_ready is sampled high.

    state_t           state_q, state_d;
    logic             started_q, started_d;
    logic             last_q, last_d;
    logic [7:0]       a_q, a_d;
    logic [7:0]       b_q, b_d;
    logic             id_q, id_d;
    logic             sign_q, sign_d;
    logic [EXP_W-1:0] exp_q, exp_d;
    logic [MAG_W-1:0] mag_q, mag_d;
    logic             res_valid_q, res_valid_d;
    logic [7:0]       res_data_q, res_data_d;
    logic             res_id_q, res_id_d;
    logic             res_zero_q, res_zero_d;
    logic             res_ovf_q, res_ovf_d;
    logic             res_unf_q, res_unf_d;

    logic             grant0;
    logic             grant1;
    logic             core_sign;
    logic [EXP_W-1:0] core_exp;
    logic [MAG_W-1:0] core_mag;

    fp_add8_core u_core (
        .a        (a_q),
        .b        (b_q),
        .sum_sign (core_sign),
        .sum_exp  (core_exp),
        .sum_mag  (core_mag)
    );

    // last_q holds the index granted most recently; the other one wins a contention.
    always_comb begin
        grant0 = req0_valid & (~req1_valid | last_q);
        grant1 = req1_valid & (~req0_valid | ~last_q);
    end

    // started_q keeps both readies low while reset is applied and until the first edge after it.
    assign req0_ready = started_q & (state_q == IDLE) & grant0;
    assign req1_ready = started_q & (state_q == IDLE) & grant1;

    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;
    assign res_id    = res_id_q;
    assign res_zero  = res_zero_q;
    assign res_ovf   = res_ovf_q;
    assign res_unf   = res_unf_q;
    assign dbg_state = state_q;

    always_comb begin
        state_d     = state_q;
        started_d   = 1'b1;
        last_d      = last_q;
        a_d         = a_q;
        b_d         = b_q;
        id_d        = id_q;
        sign_d      = sign_q;
        exp_d       = exp_q;
        mag_d       = mag_q;
        res_valid_d = res_valid_q;
        res_data_d  = res_data_q;
        res_id_d    = res_id_q;
        res_zero_d  = res_zero_q;
        res_ovf_d   = res_ovf_q;
        res_unf_d   = res_unf_q;

        case (state_q)
            IDLE: begin
                if (started_q && (grant0 || grant1)) begin
                    a_d     = grant1 ? req1_a : req0_a;
                    b_d     = grant1 ? req1_b : req0_b;
                    id_d    = grant1;
                    last_d  = grant1;
                    state_d = ADD;
                end
            end
            ADD: begin
                sign_d  = core_sign;
                exp_d   = core_exp;
                mag_d   = core_mag;
                state_d = NORM;
            end
            NORM: begin
                if (mag_q == '0) begin
                    res_data_d  = 8'h00;
                    res_zero_d  = 1'b1;
                    res_ovf_d   = 1'b0;
                    res_unf_d   = 1'b0;
                    res_id_d    = id_q;
                    res_valid_d = 1'b1;
                    state_d     = DONE;
                end else if (mag_q[5]) begin
                    if (exp_q == EXP_MAX) begin
                        res_data_d  = {sign_q, MAX_MAG[6:0]};
                        res_zero_d  = 1'b0;
                        res_ovf_d   = 1'b1;
                        res_unf_d   = 1'b0;
                        res_id_d    = id_q;
                        res_valid_d = 1'b1;
                        state_d     = DONE;
                    end else begin
                        mag_d = mag_q >> 1;
                        exp_d = exp_q + 3'd1;
                    end
                end else if (mag_q[5:4] == 2'b00) begin
                    // Below the smallest exponent the value flushes to zero.
                    if (exp_q == '0) begin
                        res_data_d  = 8'h00;
                        res_zero_d  = 1'b1;
                        res_ovf_d   = 1'b0;
                        res_unf_d   = 1'b1;
                        res_id_d    = id_q;
                        res_valid_d = 1'b1;
                        state_d     = DONE;
                    end else begin
                        mag_d = mag_q << 1;
                        exp_d = exp_q - 3'd1;
                    end
                end else begin
                    res_data_d  = pack_fp(sign_q, exp_q, mag_q[3:0]);
                    res_zero_d  = 1'b0;
                    res_ovf_d   = 1'b0;
                    res_unf_d   = 1'b0;
                    res_id_d    = id_q;
                    res_valid_d = 1'b1;
                    state_d     = DONE;
                end
            end
            DONE: begin
                if (res_ready) begin
                    res_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            started_q   <= 1'b0;
            last_q      <= 1'b1;
            a_q         <= '0;
            b_q         <= '0;
            id_q        <= 1'b0;
            sign_q      <= 1'b0;
            exp_q       <= '0;
            mag_q       <= '0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_id_q    <= 1'b0;
            res_zero_q  <= 1'b0;
            res_ovf_q   <= 1'b0;
            res_unf_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            started_q   <= started_d;
            last_q      <= last_d;
            a_q         <= a_d;
            b_q         <= b_d;
            id_q        <= id_d;
            sign_q      <= sign_d;
            exp_q       <= exp_d;
            mag_q       <= mag_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            res_id_q    <= res_id_d;
            res_zero_q  <= res_zero_d;
            res_ovf_q   <= res_ovf_d;
            res_unf_q   <= res_unf_d;
        end
    end

endmodule

// File: tb/tb_fp_add_scheduler.sv
// Directed bench for fp_add_scheduler: hand-computed sums, latency, arbitration order,
// result stalling and mid-operation reset.
module tb_fp_add_scheduler;
    import fp8_pkg::*;

    logic       clk;
    logic       reset;
    logic       req0_valid, req1_valid;
    logic [7:0] req0_a, req0_b, req1_a, req1_b;
    logic       req0_ready, req1_ready;
    logic       res_valid, res_ready;
    logic [7:0] res_data;
    logic       res_id, res_zero, res_ovf, res_unf;
    state_t     dbg_state;

    int checks = 0;
    int errors = 0;
    int both_hi = 0;

    // {id, zero, ovf, unf, data}
    logic [11:0] exp_q[$];

    fp_add_scheduler dut (
        .clk        (clk),
        .reset      (reset),
        .req0_valid (req0_valid),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_ready (req1_ready),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_data   (res_data),
        .res_id     (res_id),
        .res_zero   (res_zero),
        .res_ovf    (res_ovf),
        .res_unf    (res_unf),
        .dbg_state  (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL global_timeout");
        $fatal(1, "simulation did not finish");
    end

    // ---------------- checker ----------------
    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // ---------------- scoreboard / monitors ----------------
    always @(negedge clk) begin
        if (req0_ready && req1_ready) both_hi++;
    end

    always @(negedge clk) begin
        if (!reset && res_valid && res_ready) begin
            if (exp_q.size() == 0) begin
                check_eq("sb_unexpected", 32'd1, 32'd0);
            end else begin
                logic [11:0] e;
                e = exp_q.pop_front();
                check_eq("sb_result", {20'd0, res_id, res_zero, res_ovf, res_unf, res_data}, {20'd0, e});
            end
        end
    end

    // ---------------- drivers ----------------
    task automatic run_op(input int rid, input logic [7:0] a, input logic [7:0] b,
                          input int exp_lat, input logic [7:0] exp_data,
                          input logic ez, input logic eo, input logic eu);
        int  waited;
        int  lat;
        bit  got;
        @(negedge clk);
        if (rid == 0) begin
            req0_valid = 1'b1; req0_a = a; req0_b = b;
        end else begin
            req1_valid = 1'b1; req1_a = a; req1_b = b;
        end
        waited = 0;
        got    = 0;
        while (!got && waited < 50) begin
            #1;
            if ((rid == 0 && req0_ready) || (rid == 1 && req1_ready)) got = 1;
            else begin
                @(negedge clk);
                waited++;
            end
        end
        check_eq("accept_timeout", {31'd0, got}, 32'd1);
        if (got) begin
            @(posedge clk);
            exp_q.push_back({rid[0], ez, eo, eu, exp_data});
            #1;
            req0_valid = 1'b0;
            req1_valid = 1'b0;
            lat = 0;
            while (!res_valid && lat < 20) begin
                @(posedge clk);
                lat++;
                #1;
            end
            check_eq("latency", lat, exp_lat);
            check_eq("res_data", {24'd0, res_data}, {24'd0, exp_data});
            check_eq("res_id", {31'd0, res_id}, rid);
            check_eq("flags", {29'd0, res_zero, res_ovf, res_unf}, {29'd0, ez, eo, eu});
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int order[3];
        int waited;
        int spurious;
        bit got;

        reset      = 1'b1;
        res_ready  = 1'b1;
        req0_valid = 1'b1; req0_a = 8'h52; req0_b = 8'h42;
        req1_valid = 1'b1; req1_a = 8'hD2; req1_b = 8'h42;
        #1;
        check_eq("rst_ready0", {31'd0, req0_ready}, 32'd0);
        check_eq("rst_ready1", {31'd0, req1_ready}, 32'd0);
        check_eq("rst_outputs", {27'd0, res_valid, res_id, res_zero, res_ovf, res_unf}, 32'd0);
        check_eq("rst_data", {24'd0, res_data}, 32'd0);
        check_eq("rst_state", {30'd0, dbg_state}, {30'd0, IDLE});
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check_eq("ready_before_first_edge", {31'd0, req0_ready | req1_ready}, 32'd0);
        req0_valid = 1'b0;
        req1_valid = 1'b0;

        // Round-robin with both requesters held valid.
        @(negedge clk);
        req0_valid = 1'b1; req0_a = 8'h52; req0_b = 8'h42;
        req1_valid = 1'b1; req1_a = 8'hD2; req1_b = 8'h42;
        for (int k = 0; k < 3; k++) begin
            got    = 0;
            waited = 0;
            while (!got && waited < 50) begin
                #1;
                if (req0_ready || req1_ready) got = 1;
                else begin
                    @(negedge clk);
                    waited++;
                end
            end
            check_eq("rr_accept_timeout", {31'd0, got}, 32'd1);
            order[k] = req1_ready ? 1 : 0;
            @(posedge clk);
            if (order[k] == 0) exp_q.push_back({1'b0, 3'b000, 8'h5B});
            else               exp_q.push_back({1'b1, 3'b000, 8'hC2});
            @(negedge clk);
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        check_eq("rr_order0", order[0], 32'd0);
        check_eq("rr_order1", order[1], 32'd1);
        check_eq("rr_order2", order[2], 32'd0);
        waited = 0;
        while (exp_q.size() != 0 && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        check_eq("rr_drain", exp_q.size(), 32'd0);

        // Directed arithmetic vectors.
        run_op(0, 8'h52, 8'h42, 2, 8'h5B, 1'b0, 1'b0, 1'b0);
        run_op(1, 8'hD2, 8'h42, 3, 8'hC2, 1'b0, 1'b0, 1'b0);
        run_op(0, 8'h7F, 8'h7F, 2, 8'h7F, 1'b0, 1'b1, 1'b0);
        run_op(1, 8'h52, 8'hD2, 2, 8'h00, 1'b1, 1'b0, 1'b0);
        run_op(0, 8'h05, 8'h80, 2, 8'h00, 1'b1, 1'b0, 1'b1);
        run_op(1, 8'h52, 8'h52, 3, 8'h62, 1'b0, 1'b0, 1'b0);
        run_op(0, 8'h58, 8'hD7, 6, 8'h10, 1'b0, 1'b0, 1'b0);
        run_op(1, 8'h30, 8'hB1, 5, 8'h00, 1'b1, 1'b0, 1'b1);

        // Stall the result for five cycles.
        @(posedge clk);
        #1;
        res_ready = 1'b0;
        run_op(1, 8'h52, 8'h42, 2, 8'h5B, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_eq("stall_hold",
                     {20'd0, res_valid, res_id, res_zero, res_ovf, res_unf, dbg_state, res_data[4:0]},
                     {20'd0, 1'b1, 1'b1, 3'b000, DONE, 5'h1B});
            check_eq("stall_data", {24'd0, res_data}, 32'h5B);
        end
        @(posedge clk);
        #1;
        res_ready = 1'b1;
        @(posedge clk);
        #1;
        check_eq("stall_release", {31'd0, res_valid}, 32'd0);

        // Reset while an operation is in NORM.
        @(negedge clk);
        req1_valid = 1'b1; req1_a = 8'hD2; req1_b = 8'h42;
        got    = 0;
        waited = 0;
        while (!got && waited < 50) begin
            #1;
            if (req1_ready) got = 1;
            else begin
                @(negedge clk);
                waited++;
            end
        end
        check_eq("mid_accept_timeout", {31'd0, got}, 32'd1);
        @(posedge clk);
        #1;
        req1_valid = 1'b0;
        check_eq("mid_state_add", {30'd0, dbg_state}, {30'd0, ADD});
        @(posedge clk);
        #1;
        check_eq("mid_state_norm", {30'd0, dbg_state}, {30'd0, NORM});
        reset      = 1'b1;
        req0_valid = 1'b1;
        #1;
        check_eq("mid_rst_state", {30'd0, dbg_state}, {30'd0, IDLE});
        check_eq("mid_rst_outputs", {27'd0, res_valid, res_id, res_zero, res_ovf, res_unf}, 32'd0);
        check_eq("mid_rst_data", {24'd0, res_data}, 32'd0);
        check_eq("mid_rst_ready", {31'd0, req0_ready | req1_ready}, 32'd0);
        @(negedge clk);
        req0_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        spurious = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (res_valid) spurious++;
        end
        check_eq("no_spurious_valid", spurious, 32'd0);
        check_eq("post_rst_state", {30'd0, dbg_state}, {30'd0, IDLE});

        check_eq("sb_empty", exp_q.size(), 32'd0);
        check_eq("readies_exclusive", both_hi, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
